cam_pack_selector: RTL

CAM_PACK_SELECTOR -- requirements
Module: cam_pack_selector

---
 rtl/cam_pack_selector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cam_pack_selector.sv
// Frame-synchronous selector of one display pack stream out of N_CH channels, manual or auto-scan.
// Optional build macro CAM_PACK_SELECTOR_BLANK_EN blanks DE/RGB of the new channel until its next frame start.
module cam_pack_selector #(
    parameter int N_CH    = 2,
    parameter int PACK_W  = 49,
    parameter int VS_BIT  = 46,
    parameter int DE_BIT  = 45,
    parameter int RGB_LSB = 21,
    parameter int DWELL   = 60,
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*PACK_W-1:0] i_packs,
    input  logic [CW-1:0]          sel,
    input  logic                   sel_valid,
    input  logic                   auto_en,
    output logic [PACK_W-1:0]      o_pack,
    output logic [CW-1:0]          active_ch,
    output logic                   pending,
    output logic                   switched,
    output logic                   sel_err
);

    localparam int            CNT_W   = $clog2(DWELL + 1);
    localparam logic [CW:0]   NCH_C   = (CW+1)'(N_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    typedef enum logic {RUN, PEND} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      active_q, active_d;
    logic [CW-1:0]      target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vs_prev_q;
    logic               switched_q, sel_err_q;
    logic [PACK_W-1:0]  cur_pack;
    logic               vs_cur, boundary, in_range, req_ok, req_bad, do_switch;

`ifdef CAM_PACK_SELECTOR_BLANK_EN
    logic blank_q;

    function automatic logic [PACK_W-1:0] blank_pack(input logic [PACK_W-1:0] p);
        logic [PACK_W-1:0] r;
        r                = p;
        r[DE_BIT]        = 1'b0;
        r[RGB_LSB +: 24] = 24'd0;
        return r;
    endfunction
`endif

    always_comb begin
        cur_pack = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (active_q == CW'(k)) cur_pack = i_packs[k*PACK_W +: PACK_W];
        end
    end

    assign vs_cur   = cur_pack[VS_BIT];
    assign boundary = vs_cur & ~vs_prev_q;
    assign in_range = ({1'b0, sel} < NCH_C);
    assign req_ok   = sel_valid & ~auto_en & in_range;
    assign req_bad  = sel_valid & ~auto_en & ~in_range;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        do_switch = 1'b0;
        if (auto_en) begin
            // Auto-scan never holds a queued target; the switch happens on the DWELL-th boundary itself.
            state_d = RUN;
            if (boundary) begin
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    cnt_d     = '0;
                    do_switch = 1'b1;
                    active_d  = (active_q == LAST_CH) ? '0 : active_q + CW'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            cnt_d = '0;
            case (state_q)
                RUN: begin
                    if (req_ok && sel != active_q) begin
                        target_d = sel;
                        state_d  = PEND;
                    end
                end
                PEND: begin
                    if (req_ok && sel == active_q) begin
                        state_d = RUN;
                    end else begin
                        if (req_ok) target_d = sel;
                        if (boundary) begin
                            do_switch = 1'b1;
                            active_d  = req_ok ? sel : target_q;
                            state_d   = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            active_q   <= '0;
            target_q   <= '0;
            cnt_q      <= '0;
            vs_prev_q  <= 1'b0;
            switched_q <= 1'b0;
            sel_err_q  <= 1'b0;
            o_pack     <= '0;
`ifdef CAM_PACK_SELECTOR_BLANK_EN
            blank_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            vs_prev_q  <= do_switch ? 1'b0 : vs_cur;
            switched_q <= do_switch;
            sel_err_q  <= req_bad;
`ifdef CAM_PACK_SELECTOR_BLANK_EN
            // The boundary pack opens the first full new-channel frame, so it is passed untouched.
            o_pack     <= (blank_q && !boundary) ? blank_pack(cur_pack) : cur_pack;
            blank_q    <= do_switch ? 1'b1 : (boundary ? 1'b0 : blank_q);
`else
            o_pack     <= cur_pack;
`endif
        end
    end

    assign active_ch = active_q;
    assign pending   = (state_q == PEND);
    assign switched  = switched_q;
    assign sel_err   = sel_err_q;

endmodule
